// File: rtl/idct_pkg.sv
// Shared constants and types for the 8x8 inverse DCT block decoder.
package idct_pkg;

  localparam int COS_W       = 16;
  localparam int ROUND_CONST = 1 << 13;
  localparam int PIX_MAX     = 255;
  localparam int PIX_MIN     = -256;

  typedef logic signed [COS_W-1:0] cos_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROW,
    COL,
    DONE
  } state_t;

  // IDCT_COS[k][u] = alpha(u) * cos((2k+1)u*pi/16), Q1.14 rounded to nearest
  localparam cos_t IDCT_COS [8][8] = '{
    '{16'sd5793,  16'sd8035,  16'sd7568,  16'sd6811,  16'sd5793,  16'sd4551,  16'sd3135,  16'sd1598},
    '{16'sd5793,  16'sd6811,  16'sd3135, -16'sd1598, -16'sd5793, -16'sd8035, -16'sd7568, -16'sd4551},
    '{16'sd5793,  16'sd4551, -16'sd3135, -16'sd8035, -16'sd5793,  16'sd1598,  16'sd7568,  16'sd6811},
    '{16'sd5793,  16'sd1598, -16'sd7568, -16'sd4551,  16'sd5793,  16'sd6811, -16'sd3135, -16'sd8035},
    '{16'sd5793, -16'sd1598, -16'sd7568,  16'sd4551,  16'sd5793, -16'sd6811, -16'sd3135,  16'sd8035},
    '{16'sd5793, -16'sd4551, -16'sd3135,  16'sd8035, -16'sd5793, -16'sd1598,  16'sd7568, -16'sd6811},
    '{16'sd5793, -16'sd6811,  16'sd3135,  16'sd1598, -16'sd5793,  16'sd8035, -16'sd7568,  16'sd4551},
    '{16'sd5793, -16'sd8035,  16'sd7568, -16'sd6811,  16'sd5793, -16'sd4551,  16'sd3135, -16'sd1598}
  };

endpackage

// File: rtl/decompress_block_if.sv
// Block-level bus of the decompressor: request, coefficient/quant inputs, pixel results.
interface decompress_block_if #(
  parameter int BLOCK_SIZE  = 8,
  parameter int QCOEF_WIDTH = 12
);
  logic                          start_block;
  logic signed [QCOEF_WIDTH-1:0] qcoeffs_in  [BLOCK_SIZE][BLOCK_SIZE];
  logic        [7:0]             quant_table [BLOCK_SIZE][BLOCK_SIZE];
  logic signed [8:0]             pixels_out  [BLOCK_SIZE][BLOCK_SIZE];
  logic                          busy;
  logic                          block_done;

  modport master (
    output start_block, qcoeffs_in, quant_table,
    input  pixels_out, busy, block_done
  );

  modport slave (
    input  start_block, qcoeffs_in, quant_table,
    output pixels_out, busy, block_done
  );
endinterface

// File: rtl/decompress_block_dot8.sv
// Combinational 8-term signed dot product of data against one IDCT cosine row.
module idct_dot8
  import idct_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int SUM_W  = DATA_W + COS_W + 3
) (
  input  logic signed [DATA_W-1:0] data [8],
  input  logic        [2:0]        row,
  output logic signed [SUM_W-1:0]  sum
);
  always_comb begin
    sum = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      sum = sum + SUM_W'(data[j]) * SUM_W'(IDCT_COS[row][j]);
    end
  end
endmodule

// File: rtl/ff_en.sv
// Enabled register with asynchronous active-low reset to a parameterised value.
module ff_en #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

// File: rtl/decompress_block.sv
// 8x8 block decoder: dequantize, then row and column IDCT passes, one element per cycle.
module decompress_block
  import idct_pkg::*;
#(
  parameter int BLOCK_SIZE  = 8,
  parameter int QCOEF_WIDTH = 12,
  parameter int INTER_WIDTH = 24,
  parameter int COS_FRAC    = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  decompress_block_if.slave   bus
);
  localparam int FW    = QCOEF_WIDTH + 9;
  localparam int SUM_W = INTER_WIDTH + COS_W + 3;

  state_t      state, state_d;
  logic [2:0]  state_q;
  logic [5:0]  idx, idx_d;
  logic        idx_en;
  logic        accept;

  logic signed [QCOEF_WIDTH-1:0] q_reg   [BLOCK_SIZE][BLOCK_SIZE];
  logic        [7:0]             qt_reg  [BLOCK_SIZE][BLOCK_SIZE];
  logic signed [INTER_WIDTH-1:0] t_mem   [BLOCK_SIZE][BLOCK_SIZE];
  logic signed [8:0]             pix_reg [BLOCK_SIZE][BLOCK_SIZE];

  logic signed [FW-1:0]          deq      [BLOCK_SIZE];
  logic signed [INTER_WIDTH-1:0] dot_data [8];
  logic        [2:0]             dot_row;
  logic signed [SUM_W-1:0]       dot_sum;
  logic signed [SUM_W-1:0]       rounded;
  logic signed [8:0]             pix_sat;

  assign state  = state_t'(state_q);
  assign accept = (state == IDLE) && bus.start_block;
  assign idx_en = (state == LOAD) || (state == ROW) || (state == COL);

  ff_en #(.WIDTH(3), .RESET_VAL(3'(IDLE))) u_state_reg (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(state_d), .q(state_q)
  );

  ff_en #(.WIDTH(6), .RESET_VAL(6'd0)) u_idx_reg (
    .clk(clk), .rst_n(rst_n), .en(idx_en), .d(idx_d), .q(idx)
  );

  always_comb begin
    state_d = state;
    idx_d   = idx;
    unique case (state)
      IDLE: if (bus.start_block) state_d = LOAD;
      LOAD: begin
        state_d = ROW;
        idx_d   = '0;
      end
      ROW: begin
        idx_d = idx + 6'd1;
        if (idx == 6'd63) state_d = COL;
      end
      COL: begin
        idx_d = idx + 6'd1;
        if (idx == 6'd63) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Dequantized row u = idx[5:3]; the quant step is widened as a non-negative signed value
  always_comb begin
    for (int unsigned j = 0; j < BLOCK_SIZE; j++) begin
      deq[j] = FW'(q_reg[idx[5:3]][j]) * FW'($signed({1'b0, qt_reg[idx[5:3]][j]}));
    end
  end

  // One shared dot product: ROW uses F[u][*] with cosine row y, COL uses T[*][y] with row x
  always_comb begin
    dot_row = idx[2:0];
    for (int unsigned j = 0; j < 8; j++) begin
      dot_data[j] = INTER_WIDTH'(deq[j]);
    end
    if (state == COL) begin
      dot_row = idx[5:3];
      for (int unsigned j = 0; j < 8; j++) begin
        dot_data[j] = t_mem[j][idx[2:0]];
      end
    end
  end

  idct_dot8 #(.DATA_W(INTER_WIDTH), .SUM_W(SUM_W)) u_dot (
    .data(dot_data), .row(dot_row), .sum(dot_sum)
  );

  always_comb begin
    rounded = (dot_sum + SUM_W'(ROUND_CONST)) >>> COS_FRAC;
    if (rounded > SUM_W'(PIX_MAX)) begin
      pix_sat = 9'(PIX_MAX);
    end else if (rounded < SUM_W'(PIX_MIN)) begin
      pix_sat = 9'(PIX_MIN);
    end else begin
      pix_sat = rounded[8:0];
    end
  end

  // Operands are latched on the accept edge, so the LOAD cycle already holds the block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
        for (int unsigned j = 0; j < BLOCK_SIZE; j++) begin
          q_reg[i][j]   <= '0;
          qt_reg[i][j]  <= '0;
          t_mem[i][j]   <= '0;
          pix_reg[i][j] <= '0;
        end
      end
    end else begin
      if (accept) begin
        for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
          for (int unsigned j = 0; j < BLOCK_SIZE; j++) begin
            q_reg[i][j]  <= bus.qcoeffs_in[i][j];
            qt_reg[i][j] <= bus.quant_table[i][j];
          end
        end
      end
      if (state == ROW) begin
        t_mem[idx[5:3]][idx[2:0]] <= rounded[INTER_WIDTH-1:0];
      end
      if (state == COL) begin
        pix_reg[idx[5:3]][idx[2:0]] <= pix_sat;
      end
    end
  end

  assign bus.pixels_out = pix_reg;
  assign bus.busy       = (state != IDLE);
  assign bus.block_done = (state == DONE);

endmodule

// File: tb/tb_decompress_block.sv
// Directed bench for decompress_block with a real-valued cosine model and result scoreboard.
module tb_decompress_block;
  logic clk;
  logic rst_n;

  decompress_block_if #(.BLOCK_SIZE(8), .QCOEF_WIDTH(12)) bus ();

  decompress_block #(
    .BLOCK_SIZE(8), .QCOEF_WIDTH(12), .INTER_WIDTH(24), .COS_FRAC(14)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cos_tb [8][8];
  logic [575:0] sb [$];
  int ac_exp [8] = '{7, 6, 4, 1, -1, -4, -6, -7};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int qv, input int tv);
    for (int u = 0; u < 8; u++) begin
      for (int v = 0; v < 8; v++) begin
        bus.qcoeffs_in[u][v]  = 12'(qv);
        bus.quant_table[u][v] = 8'(tv);
      end
    end
  endtask

  task automatic fill_random(input int qmax, input int tmax);
    int r;
    for (int u = 0; u < 8; u++) begin
      for (int v = 0; v < 8; v++) begin
        r = int'($urandom_range(0, 2 * qmax)) - qmax;
        bus.qcoeffs_in[u][v]  = 12'(r);
        bus.quant_table[u][v] = 8'($urandom_range(0, tmax));
      end
    end
  endtask

  function automatic logic [575:0] model_block();
    longint f [8][8];
    longint t [8][8];
    longint s;
    logic signed [8:0] p;
    logic [575:0] r;
    r = '0;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++)
        f[u][v] = longint'(bus.qcoeffs_in[u][v]) * longint'(bus.quant_table[u][v]);
    for (int u = 0; u < 8; u++) begin
      for (int y = 0; y < 8; y++) begin
        s = 0;
        for (int v = 0; v < 8; v++) s += f[u][v] * cos_tb[y][v];
        t[u][y] = (s + 8192) >>> 14;
      end
    end
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        s = 0;
        for (int u = 0; u < 8; u++) s += cos_tb[x][u] * t[u][y];
        s = (s + 8192) >>> 14;
        if (s > 255) s = 255;
        if (s < -256) s = -256;
        p = 9'(s);
        r[(x*8+y)*9 +: 9] = p;
      end
    end
    return r;
  endfunction

  function automatic int nonzero_pixels();
    int n = 0;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        if (bus.pixels_out[x][y] !== 9'sd0) n++;
    return n;
  endfunction

  task automatic check_block(input string tag);
    logic [575:0] e;
    check({tag, "_sb_avail"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 8; y++)
          check($sformatf("%s_px[%0d][%0d]", tag, x, y), bus.pixels_out[x][y],
                $signed(e[(x*8+y)*9 +: 9]));
    end
  endtask

  // Starts from IDLE; expected result is taken from the inputs on the accept edge
  task automatic do_block(input string tag);
    int n;
    bus.start_block = 1'b1;
    sb.push_back(model_block());
    tick();
    bus.start_block = 1'b0;
    tick();
    fill_random(2047, 255);
    n = 1;
    while (bus.block_done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_done_latency"}, n, 129);
    check({tag, "_busy_at_done"}, bus.busy, 1);
    check_block(tag);
    tick();
    check({tag, "_done_width"}, bus.block_done, 0);
    check({tag, "_busy_drop"}, bus.busy, 0);
  endtask

  initial begin
    int n;
    int dones;
    real a, c;

    for (int k = 0; k < 8; k++) begin
      for (int u = 0; u < 8; u++) begin
        a = (u == 0) ? $sqrt(0.125) : 0.5;
        c = a * $cos((2 * k + 1) * u * 3.14159265358979323846 / 16.0) * 16384.0;
        cos_tb[k][u] = (c >= 0.0) ? $rtoi(c + 0.5) : -$rtoi(-c + 0.5);
      end
    end

    rst_n = 1'b0;
    bus.start_block = 1'b0;
    set_all(0, 1);
    repeat (3) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.block_done, 0);
    check("rst_pixels_nonzero", nonzero_pixels(), 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", bus.busy, 0);

    set_all(0, 1);
    do_block("zero");
    check("zero_nonzero_pixels", nonzero_pixels(), 0);

    set_all(0, 1);
    bus.qcoeffs_in[0][0] = 12'sd8;
    bus.quant_table[0][0] = 8'd16;
    do_block("dc");
    check("dc_px_const_a", bus.pixels_out[4][1], 16);
    check("dc_px_const_b", bus.pixels_out[7][7], 16);

    set_all(0, 1);
    bus.qcoeffs_in[1][0] = 12'sd4;
    bus.quant_table[1][0] = 8'd10;
    do_block("ac");
    for (int x = 0; x < 8; x++)
      check($sformatf("ac_row%0d_const", x), bus.pixels_out[x][(x * 3) % 8], ac_exp[x]);

    set_all(0, 1);
    bus.qcoeffs_in[0][0] = 12'sd2047;
    bus.quant_table[0][0] = 8'd8;
    do_block("sat_hi");
    check("sat_hi_const", bus.pixels_out[3][6], 255);

    set_all(0, 1);
    bus.qcoeffs_in[0][0] = -12'sd2048;
    bus.quant_table[0][0] = 8'd8;
    do_block("sat_lo");
    check("sat_lo_const", bus.pixels_out[6][2], -256);

    fill_random(20, 16);
    do_block("rand_a");

    // Abort during the column pass
    fill_random(20, 16);
    bus.start_block = 1'b1;
    tick();
    bus.start_block = 1'b0;
    repeat (79) tick();
    check("abort_busy_before", bus.busy, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.block_done, 0);
    check("abort_pixels_nonzero", nonzero_pixels(), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (bus.block_done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_idle_busy", bus.busy, 0);

    fill_random(20, 16);
    do_block("after_abort");

    // Start held high with inputs changing every cycle
    dones = 0;
    bus.start_block = 1'b1;
    for (int cyc = 0; cyc < 3 * 131; cyc++) begin
      fill_random(20, 16);
      if (cyc % 131 == 0) sb.push_back(model_block());
      tick();
      if (bus.block_done === 1'b1) begin
        dones++;
        check("held_done_phase", cyc % 131, 129);
        check_block($sformatf("held%0d", dones));
      end
    end
    bus.start_block = 1'b0;
    check("held_done_count", dones, 3);
    n = 0;
    while (bus.busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("held_final_idle", bus.busy, 0);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
